// File: rtl/top_chip_pkg.sv
// Shared constants and types for top_chip: memory map, SPI commands,
// core opcodes and the SPI frame state encoding.
package top_chip_pkg;

    localparam logic [31:0] MEM_BASE_DEF = 32'h0000_0080;

    localparam logic [7:0]  CMD_WRITE    = 8'h02;
    localparam logic [7:0]  CMD_READ     = 8'h0B;

    localparam logic [31:0] INSTR_HALT   = 32'h0000_0FFF;

    typedef enum logic [3:0] {
        OP_LDI  = 4'h1,
        OP_ADDI = 4'h2,
        OP_OUT  = 4'h3,
        OP_JMP  = 4'h4
    } opcode_e;

    typedef enum logic [2:0] {
        SPI_IDLE = 3'd0,
        SPI_CMD  = 3'd1,
        SPI_ADDR = 3'd2,
        SPI_DATA = 3'd3,
        SPI_DONE = 3'd4
    } spi_state_e;

endpackage

// File: rtl/top_chip_if.sv
// Program memory port between the SPI slave (master side) and the memory
// array in top_chip (slave side): one write port, one combinational read port.
interface top_chip_if #(
    parameter int AW = 5
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [AW-1:0] raddr;
    logic [31:0]   rdata;

    modport master (output we, waddr, wdata, raddr, input rdata);
    modport slave  (input we, waddr, wdata, raddr, output rdata);
endinterface

// File: rtl/spi_slave_regif.sv
// Mode-0 SPI slave: pad synchronizers, sclk/cs edge detection in the clk
// domain, cmd/addr/data frame FSM and the program memory access port.
module spi_slave_regif
    import top_chip_pkg::*;
#(
    parameter int          MEM_WORDS   = 32,
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sclk_i,
    input  logic        cs_i,
    input  logic        sdi_i,
    output logic        sdo_o,
    top_chip_if.master  mem_bus
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sdi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, sdi_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    spi_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] tx_q, tx_d;
    logic        tx_load_q, tx_load_d;

    logic [31:0] addr_off;
    logic        addr_hit;
    logic [31:0] rd_word;

    // Pad synchronizers plus one extra flop per clock/select for edge detection.
    // Everything clears to 0 so a cs held low through reset does not look like a frame start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // Address decode: word aligned and inside the program window.
    assign addr_off = addr_q - MEM_BASE;
    assign addr_hit = (addr_q >= MEM_BASE) && (addr_off < 32'(MEM_WORDS * 4)) &&
                      (addr_q[1:0] == 2'b00);
    assign rd_word  = addr_hit ? mem_bus.rdata : 32'h0;

    assign mem_bus.raddr = AW'(addr_off >> 2);
    assign mem_bus.waddr = AW'(addr_off >> 2);
    assign mem_bus.wdata = data_q;
    assign mem_bus.we    = (state_q == SPI_DONE) && (cmd_q == CMD_WRITE) && addr_hit;

    assign sdo_o = (state_q == SPI_DATA) && (cmd_q == CMD_READ) ? tx_q[31] : 1'b0;

    // Frame FSM: cs high always wins, a cs fall restarts; bits shift in on sclk rise,
    // read data shifts out on sclk fall (first fall of the data phase loads the word).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tx_d      = tx_q;
        tx_load_d = tx_load_q;
        if (cs_s) begin
            state_d = SPI_IDLE;
        end else if (cs_fall) begin
            state_d   = SPI_CMD;
            cnt_d     = '0;
            cmd_d     = '0;
            addr_d    = '0;
            data_d    = '0;
            tx_d      = '0;
            tx_load_d = 1'b0;
        end else begin
            case (state_q)
                SPI_CMD: if (sclk_rise) begin
                    cmd_d = {cmd_q[6:0], sdi_s};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d   = '0;
                        // unknown commands park in IDLE until cs rises
                        state_d = (cmd_d == CMD_WRITE || cmd_d == CMD_READ) ? SPI_ADDR : SPI_IDLE;
                    end
                end
                SPI_ADDR: if (sclk_rise) begin
                    addr_d = {addr_q[30:0], sdi_s};
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        cnt_d     = '0;
                        tx_load_d = 1'b1;
                        state_d   = SPI_DATA;
                    end
                end
                SPI_DATA: begin
                    if (sclk_fall) begin
                        tx_d      = tx_load_q ? rd_word : {tx_q[30:0], 1'b0};
                        tx_load_d = 1'b0;
                    end
                    if (sclk_rise) begin
                        data_d = {data_q[30:0], sdi_s};
                        cnt_d  = cnt_q + 5'd1;
                        if (cnt_q == 5'd31) state_d = SPI_DONE;
                    end
                end
                SPI_DONE: state_d = SPI_IDLE;
                default:  state_d = SPI_IDLE;
            endcase
        end
    end

    // Frame state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= SPI_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            tx_q      <= '0;
            tx_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            tx_load_q <= tx_load_d;
        end
    end

endmodule

// File: rtl/top_chip.sv
// Chip top: program memory loaded over SPI, and a tiny accumulator core
// (PC/ACC/GPIO) executing one instruction per clk while both enables are high.
module top_chip
    import top_chip_pkg::*;
#(
    parameter int          MEM_WORDS   = 32,
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk_i_PAD,
    input  logic        rst_i_PAD,
    input  logic        fetch_enable_i_PAD,
    input  logic        en_ifetch_i_PAD,
    input  logic        spi_sclk_PAD,
    input  logic        spi_cs_PAD,
    output logic [1:0]  spi_mode_PAD,
    input  logic        spi_sdi0_PAD,
    input  logic        spi_sdi1_PAD,
    input  logic        spi_sdi2_PAD,
    input  logic        spi_sdi3_PAD,
    output logic        spi_sdo0_PAD,
    output logic        spi_sdo1_PAD,
    output logic        spi_sdo2_PAD,
    output logic        spi_sdo3_PAD,
    output logic [31:0] gpio_o_PAD
);
    localparam int AW = $clog2(MEM_WORDS);

    top_chip_if #(.AW(AW)) mem_bus ();

    spi_slave_regif #(
        .MEM_WORDS   (MEM_WORDS),
        .MEM_BASE    (MEM_BASE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_spi (
        .clk_i   (clk_i_PAD),
        .rst_i   (rst_i_PAD),
        .sclk_i  (spi_sclk_PAD),
        .cs_i    (spi_cs_PAD),
        .sdi_i   (spi_sdi0_PAD),
        .sdo_o   (spi_sdo0_PAD),
        .mem_bus (mem_bus)
    );

    assign spi_mode_PAD = 2'b00;
    assign spi_sdo1_PAD = 1'b0;
    assign spi_sdo2_PAD = 1'b0;
    assign spi_sdo3_PAD = 1'b0;

    logic [31:0] mem_q [MEM_WORDS];
    logic [4:0]  pc_q, pc_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] instr;
    logic        unused_bits;

    // Program memory write port; deliberately not reset so a loaded program survives reset.
    always_ff @(posedge clk_i_PAD) begin
        if (mem_bus.we) mem_q[mem_bus.waddr] <= mem_bus.wdata;
    end

    // Both reads are combinational, so a same-cycle SPI write is seen only from the next clk.
    assign mem_bus.rdata = mem_q[mem_bus.raddr];
    assign instr         = mem_q[pc_q];

    assign unused_bits = ^{instr[27:16], spi_sdi1_PAD, spi_sdi2_PAD, spi_sdi3_PAD};

    // Instruction execute: HALT freezes PC, JMP loads it, everything else steps it.
    always_comb begin
        pc_d   = pc_q;
        acc_d  = acc_q;
        gpio_d = gpio_q;
        if (fetch_enable_i_PAD && en_ifetch_i_PAD && instr != INSTR_HALT) begin
            pc_d = pc_q + 5'd1;
            case (opcode_e'(instr[31:28]))
                OP_LDI:  acc_d  = {16'h0, instr[15:0]};
                OP_ADDI: acc_d  = acc_q + {{16{instr[15]}}, instr[15:0]};
                OP_OUT:  gpio_d = acc_q;
                OP_JMP:  pc_d   = instr[4:0];
                default: ;
            endcase
        end
    end

    // Core architectural state.
    always_ff @(posedge clk_i_PAD or posedge rst_i_PAD) begin
        if (rst_i_PAD) begin
            pc_q   <= '0;
            acc_q  <= '0;
            gpio_q <= '0;
        end else begin
            pc_q   <= pc_d;
            acc_q  <= acc_d;
            gpio_q <= gpio_d;
        end
    end

    assign gpio_o_PAD = gpio_q;

endmodule

// File: tb/tb_top_chip.sv
// Directed bench for top_chip: SPI program load/readback, address decode,
// frame abort, core run/hold behaviour and asynchronous reset.
module tb_top_chip;
    import top_chip_pkg::*;

    localparam int SH = 3;  // clk cycles per sclk half period (sclk = clk/6)

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        fe   = 1'b0;
    logic        ei   = 1'b0;
    logic        sclk = 1'b0;
    logic        cs   = 1'b1;
    logic        sdi  = 1'b0;
    logic        sdi1 = 1'b0, sdi2 = 1'b0, sdi3 = 1'b0;
    logic [1:0]  mode;
    logic        sdo0, sdo1, sdo2, sdo3;
    logic [31:0] gpio;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    top_chip dut (
        .clk_i_PAD          (clk),
        .rst_i_PAD          (rst),
        .fetch_enable_i_PAD (fe),
        .en_ifetch_i_PAD    (ei),
        .spi_sclk_PAD       (sclk),
        .spi_cs_PAD         (cs),
        .spi_mode_PAD       (mode),
        .spi_sdi0_PAD       (sdi),
        .spi_sdi1_PAD       (sdi1),
        .spi_sdi2_PAD       (sdi2),
        .spi_sdi3_PAD       (sdi3),
        .spi_sdo0_PAD       (sdo0),
        .spi_sdo1_PAD       (sdo1),
        .spi_sdo2_PAD       (sdo2),
        .spi_sdo3_PAD       (sdo3),
        .gpio_o_PAD         (gpio)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One mode-0 frame of nbits bits; rst_at >= 0 pulses reset at that bit and abandons the frame.
    // sdo is sampled at the end of each low phase of the data bits.
    task automatic spi(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                       input int nbits, input int rst_at, output logic [31:0] rd);
        logic [71:0] sh;
        sh = {cmd, addr, data};
        rd = '0;
        @(negedge clk);
        cs = 1'b0;
        repeat (SH) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            sclk = 1'b0;
            sdi  = sh[71-i];
            repeat (SH) @(negedge clk);
            if (i >= 40) rd = {rd[30:0], sdo0};
            sclk = 1'b1;
            repeat (SH) @(negedge clk);
        end
        sclk = 1'b0;
        cs   = 1'b1;
        sdi  = 1'b0;
        repeat (2 * SH) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        spi(CMD_WRITE, addr, data, 72, -1, dummy);
    endtask

    task automatic rdw(input logic [31:0] addr, output logic [31:0] data);
        spi(CMD_READ, addr, 32'h0, 72, -1, data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_gpio", gpio, 32'h0);
        chk("rst_sdo", {28'h0, sdo3, sdo2, sdo1, sdo0}, 32'h0);
        chk("rst_mode", {30'h0, mode}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // fill every word with a known NOP pattern
        for (int i = 0; i < 32; i++) begin
            model[i] = 32'hA500_0000 | 32'(i);
            wr(32'h80 + 32'(4 * i), model[i]);
        end

        // program: LDI 10; ADDI 20; OUT; HALT
        model[0] = 32'h1000_000A; model[1] = 32'h2000_0014;
        model[2] = 32'h3000_0000; model[3] = 32'h0000_0FFF;
        for (int i = 0; i < 4; i++) wr(32'h80 + 32'(4 * i), model[i]);

        // a single enable never advances the core
        fe = 1'b1; ei = 1'b0;
        repeat (10) @(negedge clk);
        chk("fe_only_gpio", gpio, 32'h0);
        fe = 1'b0; ei = 1'b1;
        repeat (10) @(negedge clk);
        chk("ei_only_gpio", gpio, 32'h0);

        // three clks reach OUT only if PC stayed at 0; remaining clks sit on HALT
        fe = 1'b1; ei = 1'b1;
        repeat (3) @(negedge clk);
        chk("run3_gpio", gpio, 32'd30);
        repeat (7) @(negedge clk);
        fe = 1'b0; ei = 1'b0;
        chk("run10_gpio", gpio, 32'd30);

        // write/read back and out-of-range read
        model[1] = 32'hDEAD_BEEF;
        wr(32'h84, 32'hDEAD_BEEF);
        rdw(32'h84, rd);
        chk("rd_84", rd, 32'hDEAD_BEEF);
        rdw(32'h00, rd);
        chk("rd_00", rd, 32'h0);
        rdw(32'h100, rd);
        chk("rd_100", rd, 32'h0);

        // out-of-range and misaligned writes are dropped
        wr(32'h100, 32'h1111_1111);
        wr(32'h82,  32'h2222_2222);
        wr(32'h7C,  32'h3333_3333);
        for (int i = 0; i < 32; i++) begin
            rdw(32'h80 + 32'(4 * i), rd);
            chk($sformatf("rdback_%0d", i), rd, model[i]);
        end

        // aborted frame writes nothing, next full frame does
        spi(CMD_WRITE, 32'h88, 32'h1234_5678, 20, -1, rd);
        rdw(32'h88, rd);
        chk("abort_nowrite", rd, model[2]);
        model[2] = 32'hCAFE_F00D;
        wr(32'h88, 32'hCAFE_F00D);
        rdw(32'h88, rd);
        chk("after_abort", rd, 32'hCAFE_F00D);

        // unknown command: no sdo activity, no write
        spi(8'h55, 32'h88, 32'h0BAD_0BAD, 72, -1, rd);
        chk("unk_sdo", rd, 32'h0);
        rdw(32'h88, rd);
        chk("unk_nowrite", rd, 32'hCAFE_F00D);

        // reset in the middle of a write frame
        spi(CMD_WRITE, 32'h80, 32'hFFFF_FFFF, 72, 60, rd);
        rdw(32'h80, rd);
        chk("rst_frame_nowrite", rd, model[0]);

        // LDI FFFF; ADDI 1; OUT; HALT
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(32'h80, 32'h1000_FFFF);
        wr(32'h84, 32'h2000_0001);
        wr(32'h88, 32'h3000_0000);
        wr(32'h8C, 32'h0000_0FFF);
        fe = 1'b1; ei = 1'b1;
        repeat (3) @(negedge clk);
        chk("prog2_gpio", gpio, 32'h0001_0000);

        // asynchronous reset clears gpio without waiting for a clk edge
        rst = 1'b1;
        #1;
        chk("async_rst_gpio", gpio, 32'h0);
        @(negedge clk);
        fe = 1'b0; ei = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
